// File: rtl/tff_bank_sequencer.sv
// tff_bank_sequencer: command sequencer driving a WIDTH-bit bank of T flip-flops (q <= q ^ t_vec)
//   in : clk, reset_n (async active-low), start, stop, load, load_value, limit, up_down, wrap_en
//   out: t_vec (toggle vector for next edge), q, q_inverse, busy, terminal, done
module tff_bank_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] limit,
  input  logic             up_down,
  input  logic             wrap_en,
  output logic [WIDTH-1:0] t_vec,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_inverse,
  output logic             busy,
  output logic             terminal,
  output logic             done
);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, PAUSE, DONE} state_t;
  state_t state, state_n, ret_r, ret_n;
  logic [WIDTH-1:0] limit_r, up_t, dn_t, term_val, start_pt;
  logic dir_r, wrap_r, cap;
  // Ripple-and chains: bit i toggles when all lower bits are 1 (up) or all 0 (down).
  assign up_t[0] = 1'b1;
  assign dn_t[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_step
    assign up_t[i] = up_t[i-1] & q[i-1];
    assign dn_t[i] = dn_t[i-1] & ~q[i-1];
  end
  assign term_val  = dir_r ? limit_r : '0;
  assign start_pt  = dir_r ? '0 : limit_r;
  assign terminal  = (state == RUN) && (q == term_val);
  assign busy      = state == RUN;
  assign done      = state == DONE;
  assign q_inverse = ~q;
  always_comb begin
    state_n = state;
    ret_n   = ret_r;
    t_vec   = '0;
    cap     = 1'b0;
    unique case (state)
      IDLE: begin
        if (load) begin
          state_n = LOAD;
          ret_n   = IDLE;
        end else if (start) begin
          state_n = RUN;
          cap     = 1'b1;
        end
      end
      LOAD: begin
        t_vec   = q ^ load_value;
        state_n = ret_r;
      end
      RUN: begin
        if (stop) state_n = PAUSE;
        else if (!terminal) t_vec = dir_r ? up_t : dn_t;
        else if (wrap_r) t_vec = q ^ start_pt;
        else state_n = DONE;
      end
      PAUSE: begin
        if (load) begin
          state_n = LOAD;
          ret_n   = PAUSE;
        end else if (start) begin
          state_n = RUN;
          cap     = 1'b1;
        end
      end
      DONE: begin
        if (load) begin
          state_n = LOAD;
          ret_n   = IDLE;
        end else if (start) begin
          state_n = RUN;
          cap     = 1'b1;
          // Preset uses the incoming direction/limit since they are captured on this same edge.
          t_vec   = q ^ (up_down ? '0 : limit);
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      ret_r   <= IDLE;
      q       <= '0;
      limit_r <= '0;
      dir_r   <= 1'b1;
      wrap_r  <= 1'b0;
    end else begin
      state <= state_n;
      ret_r <= ret_n;
      q     <= q ^ t_vec;
      if (cap) begin
        limit_r <= limit;
        dir_r   <= up_down;
        wrap_r  <= wrap_en;
      end
    end
  end
endmodule

// File: tb/tb_tff_bank_sequencer.sv
// tb_tff_bank_sequencer: directed self-checking bench for tff_bank_sequencer with WIDTH = 4
module tb_tff_bank_sequencer;
  logic clk = 1'b0, reset_n = 1'b0;
  logic start = 1'b0, stop = 1'b0, load = 1'b0, up_down = 1'b0, wrap_en = 1'b0;
  logic [3:0] load_value = '0, limit = '0;
  logic [3:0] t_vec, q, q_inverse;
  logic busy, terminal, done;
  int checks = 0, errors = 0;
  logic [3:0] up_seq [5] = '{4'h1, 4'h3, 4'h1, 4'h7, 4'h1};
  tff_bank_sequencer #(.WIDTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .load(load),
    .load_value(load_value), .limit(limit), .up_down(up_down), .wrap_en(wrap_en),
    .t_vec(t_vec), .q(q), .q_inverse(q_inverse), .busy(busy), .terminal(terminal), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #12 reset_n = 1'b1;
    load = 1'b1; load_value = 4'h9;
    tick; load = 1'b0;
    tick;
    chk("preload_q", q, 4'h9);
    #3 reset_n = 1'b0;
    #1;
    chk("rst_q", q, 4'h0);
    chk("rst_qi", q_inverse, 4'hF);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_t", t_vec, 4'h0);
    chk("rst_term", terminal, 0);
    reset_n = 1'b1;
    start = 1'b1; up_down = 1'b1; limit = 4'h5; wrap_en = 1'b0;
    tick; start = 1'b0;
    chk("up_busy", busy, 1);
    chk("up_q0", q, 4'h0);
    for (int k = 0; k < 5; k++) begin
      chk("up_t", t_vec, up_seq[k]);
      tick;
      chk("up_q", q, k + 1);
    end
    chk("up_term", terminal, 1);
    chk("up_term_t", t_vec, 4'h0);
    tick;
    chk("up_done", done, 1);
    chk("up_done_q", q, 4'h5);
    chk("up_done_busy", busy, 0);
    tick;
    chk("up_hold_q", q, 4'h5);
    start = 1'b1; up_down = 1'b0; limit = 4'h7;
    #1 chk("rs_preset_t", t_vec, 4'h2);
    tick; start = 1'b0;
    chk("rs_q7", q, 4'h7);
    chk("rs_busy", busy, 1);
    for (int v = 6; v >= 0; v--) begin
      tick;
      chk("rs_dn_q", q, v);
    end
    chk("rs_term", terminal, 1);
    tick;
    chk("rs_done", done, 1);
    chk("rs_done_q", q, 4'h0);
    load = 1'b1; load_value = 4'h2;
    tick; load = 1'b0;
    chk("ld_t", t_vec, 4'h2);
    tick;
    chk("ld_q", q, 4'h2);
    chk("ld_idle_done", done, 0);
    chk("ld_idle_busy", busy, 0);
    start = 1'b1; up_down = 1'b0; limit = 4'h3; wrap_en = 1'b1;
    tick; start = 1'b0;
    chk("wr_q2", q, 4'h2);
    tick; chk("wr_q1", q, 4'h1);
    tick; chk("wr_q0", q, 4'h0);
    chk("wr_term", terminal, 1);
    chk("wr_force_t", t_vec, 4'h3);
    tick; chk("wr_q3", q, 4'h3);
    chk("wr_busy", busy, 1);
    tick; chk("wr_q2b", q, 4'h2);
    tick; chk("wr_q1b", q, 4'h1);
    tick; chk("wr_q0b", q, 4'h0);
    stop = 1'b1;
    #1 chk("st_term_t", t_vec, 4'h0);
    tick; stop = 1'b0;
    chk("st_term_q", q, 4'h0);
    chk("st_term_busy", busy, 0);
    start = 1'b1; up_down = 1'b1; limit = 4'h9; wrap_en = 1'b0;
    tick; start = 1'b0;
    tick; tick;
    chk("pr_q2", q, 4'h2);
    load = 1'b1; load_value = 4'hF;
    tick; load = 1'b0;
    chk("pr_ld_ign", q, 4'h3);
    tick;
    chk("pr_q4", q, 4'h4);
    stop = 1'b1;
    tick; stop = 1'b0;
    chk("pr_hold_q", q, 4'h4);
    chk("pr_busy", busy, 0);
    chk("pr_t", t_vec, 4'h0);
    tick;
    chk("pr_hold_q2", q, 4'h4);
    start = 1'b1;
    tick; start = 1'b0;
    chk("pr_res_busy", busy, 1);
    tick;
    chk("pr_res_q5", q, 4'h5);
    stop = 1'b1; load = 1'b1; start = 1'b1; load_value = 4'hA;
    tick; stop = 1'b0; load = 1'b0; start = 1'b0;
    chk("sim_q", q, 4'h5);
    chk("sim_busy", busy, 0);
    load = 1'b1; load_value = 4'hA;
    tick; load = 1'b0;
    tick;
    chk("pl_q", q, 4'hA);
    chk("pl_busy", busy, 0);
    chk("pl_done", done, 0);
    chk("pl_t", t_vec, 4'h0);
    start = 1'b1; up_down = 1'b1; limit = 4'hC;
    tick; start = 1'b0;
    chk("pl_run_q", q, 4'hA);
    chk("pl_run_busy", busy, 1);
    tick;
    chk("pl_run_qb", q, 4'hB);
    #2 reset_n = 1'b0;
    #1;
    chk("mr_q", q, 4'h0);
    chk("mr_busy", busy, 0);
    chk("mr_t", t_vec, 4'h0);
    chk("mr_qi", q_inverse, 4'hF);
    reset_n = 1'b1;
    tick;
    chk("mr_idle_q", q, 4'h0);
    chk("mr_idle_busy", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tff_bank_sequencer.md
Name: tff_bank_sequencer

Overview:
- Controller plus state bank for a WIDTH-bit register of T flip-flops. Each bit updates as next q = t ^ q.
- The controller generates the per-bit toggle vector each cycle to implement load, up/down counting, bounded or wrapping runs, and pause/resume.
- Sits between software-style command pulses and the T-flip-flop storage. It is the sequencer for the T-flip-flop datapath.

Parameters:
- WIDTH, 4, number of T flip-flops in the bank (≥ 2).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  start/resume command, single-cycle level sampled at posedge
- stop  in  1  pause command
- load  in  1  load command
- load_value  in  WIDTH  value applied on load
- limit  in  WIDTH  terminal/preset bound, captured into limit_r on start
- up_down  in  1  1 = count up, 0 = count down, captured into dir_r on start
- wrap_en  in  1  1 = wrap at terminal, 0 = stop at terminal, captured on start
- t_vec  out  WIDTH  combinational toggle vector applied at next edge
- q  out  WIDTH  registered bank state
- q_inverse  out  WIDTH  always ~q
- busy  out  1  state == RUN
- terminal  out  1  combinational: state == RUN and q at terminal value
- done  out  1  registered, high while state == DONE

Behaviour:
- Reset (async, reset_n low) forces:
  - q = 0, q_inverse = all ones
  - state = IDLE, limit_r = 0, dir_r = 1, wrap_r = 0
  - done = 0; busy and terminal derive to 0
- Bank update: on every posedge, q <= q ^ t_vec. q_inverse tracks with zero latency.
- Toggle generation:
  - Up step: t_vec[0] = 1; t_vec[i] = &q[i-1:0].
  - Down step: t_vec[0] = 1; t_vec[i] = &(~q[i-1:0]).
  - Forcing to a value V: t_vec = q ^ V.
  - Hold: t_vec = 0.
- Terminal value: limit_r when dir_r = 1; 0 when dir_r = 0.
- Command priority, same cycle: stop > load > start. Commands not legal in the current state are ignored.
- States:
  - IDLE (t_vec = 0):
    - load -> LOAD.
    - start -> RUN. Captures limit, up_down and wrap_en. No preset; counting continues from the current q.
  - LOAD: one cycle. t_vec = q ^ load_value, so q = load_value after the edge. Returns to the state that issued the load (IDLE, PAUSE or DONE; DONE returns to IDLE).
  - RUN:
    - stop -> PAUSE, t_vec = 0 that cycle.
    - load is ignored.
    - If q != terminal value: step in dir_r.
    - If q == terminal value (terminal = 1):
      - wrap_r = 1: force to the start point (0 for up, limit_r for down); remain in RUN.
      - wrap_r = 0: t_vec = 0 -> DONE.
    - Up count with q > limit_r rolls naturally through all-ones to 0, then up to limit_r. Down count with q > limit_r decrements to 0.
  - PAUSE (t_vec = 0):
    - start -> RUN, resuming from current q. Re-captures limit, up_down and wrap_en.
    - load -> LOAD.
  - DONE (done = 1, t_vec = 0):
    - start -> RUN with preset: t_vec forces q to the start point of the newly captured direction (0 up, captured limit down) in the transition cycle.
    - load -> LOAD -> IDLE.
- Edge cases:
  - limit = 0 with up, or q = 0 with down: terminal is true in the first RUN cycle. Result is immediately DONE, or a repeated force-to-start when wrapping.
  - stop and terminal in the same cycle: stop wins -> PAUSE; q unchanged.
  - Async reset mid-RUN or mid-LOAD: immediate return to the reset values; no partial load survives.

Test Plan (WIDTH = 4):
- Reset: assert reset_n = 0 mid-cycle -> q = 0, q_inverse = 4'hF, busy = 0, done = 0, t_vec = 0 with no clock edge required.
- Bounded up run: from q = 0, start with up_down = 1, limit = 5, wrap_en = 0 -> q steps 1, 2, 3, 4, 5 on successive edges, with t_vec = 0001, 0011, 0001, 0111, 0001. At q = 5, terminal = 1; next edge done = 1 and q holds at 5.
- Wrapping down run: load 4'h2, then start with up_down = 0, limit = 3, wrap_en = 1 -> q = 1, 0, 3, 2, 1, ... The 0 -> 3 transition uses t_vec = 0011.
- Pause/resume: up run with limit = 9; pulse stop when q = 4 -> q holds 4, busy = 0, t_vec = 0. Load ignored during RUN is not applied. start -> q = 5 on the next edge.
- Simultaneous commands: in RUN, stop + load + start together -> PAUSE, q unchanged. In PAUSE, load = 1 with load_value = 4'hA -> q = 4'hA after one edge, state back to PAUSE.
- Restart from DONE: after the bounded run (q = 5), start with up_down = 0, limit = 7 -> q = 7, then 6, 5, ..., 0 -> DONE at q = 0. Then async reset mid-run of a fresh start -> q = 0, state IDLE.
